// File: rtl/bsg_manycore_drlp_barrier_ctrl_if.sv
// Master <-> barrier-controller bundle: phase start, per-slave flags, barrier
// handshake outputs and perf counters.
interface bsg_manycore_drlp_barrier_ctrl_if #(
    parameter int num_slaves_p    = 2,
    parameter int timeout_width_p = 16
);
    logic                       start_v_i;
    logic [num_slaves_p-1:0]    slave_mask_i;
    logic [timeout_width_p-1:0] timeout_cycles_i;
    logic [num_slaves_p-1:0]    pe_ready_i;
    logic [num_slaves_p-1:0]    slave_done_i;
    logic                       done_ack_i;
    logic                       busy_o;
    logic                       all_pe_ready_o;
    logic                       all_slave_done_o;
    logic                       error_o;
    logic [num_slaves_p-1:0]    missing_o;
    logic [31:0]                wait_cycles_o;
    logic [31:0]                run_cycles_o;

    modport master (
        output start_v_i, slave_mask_i, timeout_cycles_i, pe_ready_i, slave_done_i, done_ack_i,
        input  busy_o, all_pe_ready_o, all_slave_done_o, error_o, missing_o,
               wait_cycles_o, run_cycles_o
    );

    modport slave (
        input  start_v_i, slave_mask_i, timeout_cycles_i, pe_ready_i, slave_done_i, done_ack_i,
        output busy_o, all_pe_ready_o, all_slave_done_o, error_o, missing_o,
               wait_cycles_o, run_cycles_o
    );
endinterface

// File: rtl/bsg_manycore_drlp_barrier_ctrl.sv
// DRLP barrier/phase sequencer: masked ready/done reduction with watchdog.
// Optional residency counters enabled by BSG_DRLP_BARRIER_PERF_EN.
module bsg_manycore_drlp_barrier_ctrl #(
    parameter int num_slaves_p    = 2,
    parameter int timeout_width_p = 16
) (
    input logic clk_i,
    input logic reset_i,
    bsg_manycore_drlp_barrier_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_READY = 3'd1;
    localparam logic [2:0] RUN        = 3'd2;
    localparam logic [2:0] DONE       = 3'd3;
    localparam logic [2:0] ERROR      = 3'd4;

    logic [2:0]                 state_q, state_d;
    logic [num_slaves_p-1:0]    mask_q, mask_d;
    logic [num_slaves_p-1:0]    rdy_q, rdy_d;
    logic [num_slaves_p-1:0]    done_q, done_d;
    logic [num_slaves_p-1:0]    missing_q, missing_d;
    logic [timeout_width_p-1:0] cnt_q, cnt_d;
    logic [timeout_width_p-1:0] cnt_inc;
    logic                       rdy_all, done_all, cnt_hit;
    logic                       wait_exit, run_exit;

    // Unmasked slaves are forced to "complete" so their flags never matter.
    assign rdy_all  = &((rdy_q  | bus.pe_ready_i)   | ~mask_q);
    assign done_all = &((done_q | bus.slave_done_i) | ~mask_q);
    assign cnt_hit  = (bus.timeout_cycles_i != '0) &&
                      (cnt_q == bus.timeout_cycles_i - timeout_width_p'(1));
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + timeout_width_p'(1);

    assign wait_exit = (state_q == WAIT_READY) && (rdy_all  || cnt_hit);
    assign run_exit  = (state_q == RUN)        && (done_all || cnt_hit);

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        rdy_d     = rdy_q;
        done_d    = done_q;
        missing_d = missing_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start_v_i) begin
                    mask_d  = bus.slave_mask_i;
                    rdy_d   = '0;
                    done_d  = '0;
                    cnt_d   = '0;
                    state_d = WAIT_READY;
                end
            end
            WAIT_READY: begin
                rdy_d = rdy_q | (bus.pe_ready_i & mask_q);
                cnt_d = cnt_inc;
                if (rdy_all) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (cnt_hit) begin
                    missing_d = mask_q & ~rdy_q;
                    state_d   = ERROR;
                end
            end
            RUN: begin
                done_d = done_q | (bus.slave_done_i & mask_q);
                cnt_d  = cnt_inc;
                if (done_all) begin
                    state_d = DONE;
                end else if (cnt_hit) begin
                    missing_d = mask_q & ~done_q;
                    state_d   = ERROR;
                end
            end
            DONE: begin
                if (bus.done_ack_i) state_d = IDLE;
            end
            ERROR: begin
                if (bus.done_ack_i) begin
                    missing_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            rdy_q     <= '0;
            done_q    <= '0;
            missing_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            rdy_q     <= rdy_d;
            done_q    <= done_d;
            missing_q <= missing_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.busy_o           = (state_q != IDLE);
    assign bus.all_pe_ready_o   = (state_q == RUN);
    assign bus.all_slave_done_o = (state_q == DONE);
    assign bus.error_o          = (state_q == ERROR);
    assign bus.missing_o        = missing_q;

`ifdef BSG_DRLP_BARRIER_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic [31:0] perf_inc;
    logic [31:0] wait_cycles_q, wait_cycles_d;
    logic [31:0] run_cycles_q, run_cycles_d;

    // perf_inc includes the current cycle, so the snapshot is full residency.
    assign perf_inc = (&perf_q) ? perf_q : perf_q + 32'd1;

    always_comb begin
        perf_d        = perf_q;
        wait_cycles_d = wait_cycles_q;
        run_cycles_d  = run_cycles_q;
        if (state_q == IDLE && bus.start_v_i) perf_d = '0;
        if (state_q == WAIT_READY || state_q == RUN) perf_d = perf_inc;
        if (wait_exit) begin
            wait_cycles_d = perf_inc;
            perf_d        = '0;
        end
        if (run_exit) run_cycles_d = perf_inc;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_q        <= '0;
            wait_cycles_q <= '0;
            run_cycles_q  <= '0;
        end else begin
            perf_q        <= perf_d;
            wait_cycles_q <= wait_cycles_d;
            run_cycles_q  <= run_cycles_d;
        end
    end

    assign bus.wait_cycles_o = wait_cycles_q;
    assign bus.run_cycles_o  = run_cycles_q;
`else
    logic unused_exit;
    assign unused_exit       = wait_exit ^ run_exit;
    assign bus.wait_cycles_o = '0;
    assign bus.run_cycles_o  = '0;
`endif
endmodule
